// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   N-channel push-button front end. Each channel:
//     - synchronises the raw pin with two flops,
//     - debounces it so the level only flips after DEB_CYCLES cycles of
//       disagreement,
//     - emits a one-cycle pulse on the edge(s) selected by its mode,
//     - emits a one-cycle long_press after HOLD_CYCLES cycles held,
//     - in mode 11, auto-repeats pulse every REPEAT_CYCLES cycles after
//       the long press.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn[N]      raw asynchronous button inputs, active-high
//   mode[2N]    per-channel mode, bits [2i+1:2i]:
//               00 rise, 01 fall, 10 both, 11 rise + auto-repeat
//   level[N]    debounced level
//   pulse[N]    one-cycle event pulse
//   long_press[N] one-cycle long-press pulse
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N             = 4,
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   btn,
    input  logic [2*N-1:0] mode,
    output logic [N-1:0]   level,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   long_press
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic          sync_d;
            logic          sync_q;
            logic          lvl_q;
            logic          pulse_q;
            logic          lp_q;
            logic [DW-1:0] deb_cnt;
            logic [HW-1:0] hold_cnt;
            logic [RW-1:0] rep_cnt;

            logic [1:0]    ch_mode;
            logic          upd;
            logic          rise_upd;
            logic          fall_upd;
            logic          lp_evt;
            logic          rep_evt;
            logic          evt;

            always_comb begin
                ch_mode  = mode[2*i +: 2];
                upd      = (sync_q != lvl_q) && (deb_cnt == DEB_LAST);
                rise_upd = upd && sync_q;
                fall_upd = upd && !sync_q;
                // Hold counter crossing HOLD-1 -> HOLD happens once per press
                // because it saturates and only clears while level is low.
                lp_evt   = lvl_q && (hold_cnt == HOLD_PRE);
                // A release being committed this edge cancels any repeat.
                rep_evt  = lvl_q && (hold_cnt == HOLD_MAX) &&
                           (rep_cnt == REP_LAST) && !fall_upd;
                evt      = (rise_upd && (ch_mode != 2'b01)) ||
                           (fall_upd && ((ch_mode == 2'b01) || (ch_mode == 2'b10))) ||
                           ((ch_mode == 2'b11) && (lp_evt || rep_evt));
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_d <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    sync_d <= btn[i];
                    sync_q <= sync_d;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_cnt <= '0;
                    lvl_q   <= 1'b0;
                end else if (sync_q == lvl_q) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt <= '0;
                    lvl_q   <= sync_q;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            // Level is still low on the rising-update edge, so that edge
            // also clears the hold counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                end else if (!lvl_q) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end

            // Repeat phase runs in every mode; mode only gates the pulse, so
            // switching modes mid-hold does not disturb the cadence.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rep_cnt <= '0;
                end else if (!lvl_q || lp_evt) begin
                    rep_cnt <= '0;
                end else if (hold_cnt == HOLD_MAX) begin
                    rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pulse_q <= 1'b0;
                    lp_q    <= 1'b0;
                end else begin
                    pulse_q <= evt;
                    lp_q    <= lp_evt;
                end
            end

            assign level[i]      = lvl_q;
            assign pulse[i]      = pulse_q;
            assign long_press[i] = lp_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with default parameters. A
//   timestamp-based reference model (run lengths and cycles since the last
//   rising update) is compared against the DUT on every falling clock edge,
//   and hand-computed literal expectations pin key instants.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N     = 4;
    localparam int DEB   = 4;
    localparam int HOLD  = 16;
    localparam int REP   = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   btn = '0;
    logic [2*N-1:0] mode = '0;
    logic [N-1:0]   level;
    logic [N-1:0]   pulse;
    logic [N-1:0]   long_press;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .N(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .mode(mode),
        .level(level), .pulse(pulse), .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Level flips once sync has disagreed for DEB consecutive cycles; all
    // hold/repeat events are derived from the cycle number of the last rise.
    int             cyc;
    int             m_run  [N];
    int             m_rise [N];
    logic [N-1:0]   m_s1, m_s2, m_lvl, m_pulse, m_lp;
    int             d, md;
    logic           lv, rise_u, fall_u, lp_u, rep_u;

    initial begin
        cyc = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_lp = '0;
        for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rise[i] = 0; end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_lp = '0;
            for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rise[i] = 0; end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < N; i++) begin
                lv     = m_lvl[i];
                md     = int'(mode[2*i +: 2]);
                rise_u = 1'b0;
                fall_u = 1'b0;
                if (m_s2[i] != lv) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DEB) begin
                        rise_u   = m_s2[i];
                        fall_u   = !m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                d     = cyc - m_rise[i];
                lp_u  = lv && (d == HOLD);
                rep_u = lv && !fall_u && (d > HOLD) && (((d - HOLD) % REP) == 0);
                m_lp[i]    = lp_u;
                m_pulse[i] = (rise_u && md != 1) || (fall_u && (md == 1 || md == 2)) ||
                             (md == 3 && (lp_u || rep_u));
                if (rise_u) begin m_lvl[i] = 1'b1; m_rise[i] = cyc; end
                if (fall_u) m_lvl[i] = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    always @(negedge clk) begin
        check("model_level", level, m_lvl);
        check("model_pulse", pulse, m_pulse);
        check("model_long_press", long_press, m_lp);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    logic [N-1:0] glitch_seen;
    logic [N-1:0] exp_v;
    int           rel;
    logic [7:0]   gpat;

    initial begin
        btn  = 4'hF;
        mode = 8'h00;
        step(3);
        check("reset_level", level, 4'h0);
        check("reset_pulse", pulse, 4'h0);
        check("reset_long_press", long_press, 4'h0);

        // Held through reset: rising update lands on edge 6 after release.
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 5) check("reset_hold_pre_level", level, 4'h0);
            if (k == 6) check("reset_hold_level", level, 4'hF);
            if (k == 6) check("reset_hold_pulse", pulse, 4'hF);
            if (k == 7) check("reset_hold_pulse_one_cycle", pulse, 4'h0);
        end
        btn = 4'h0;
        step(12);

        // Glitches of 3 cycles high are shorter than the debounce window.
        gpat = 8'b1110_0111;
        glitch_seen = '0;
        for (int j = 0; j < 18; j++) begin
            btn[0] = (j < 8) ? gpat[7-j] : 1'b0;
            step(1);
            glitch_seen = glitch_seen | (level & 4'h1) | (pulse & 4'h1);
        end
        check("glitch_ignored", glitch_seen, 4'h0);

        btn[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 5) check("deb_pulse_early", pulse, 4'h0);
            if (k == 6) check("deb_pulse", pulse, 4'h1);
            if (k == 7) check("deb_pulse_end", pulse, 4'h0);
        end
        btn = 4'h0;
        step(12);

        // Edge modes: ch0 rise, ch1 fall, ch2 both.
        mode = 8'b00_10_01_00;
        btn  = 4'b0111;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 6)  check("mode_press_pulse", pulse, 4'b0101);
            if (k == 10) check("mode_press_level", level, 4'b0111);
        end
        btn = 4'h0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 6) check("mode_release_pulse", pulse, 4'b0110);
            if (k == 6) check("mode_release_level", level, 4'b0000);
        end

        // Long press + auto-repeat on ch3; released early enough that the
        // level falls before the repeat at E+40.
        mode = 8'b11_00_00_00;
        btn  = 4'b1000;
        for (int j = 1; j <= 50; j++) begin
            step(1);
            rel   = j - 6;
            exp_v = (rel == 0 || rel == 16 || rel == 24 || rel == 32) ? 4'h8 : 4'h0;
            check("repeat_pulse", pulse, exp_v);
            exp_v = (rel == 16) ? 4'h8 : 4'h0;
            check("repeat_long_press", long_press, exp_v);
            if (j == 35) btn = 4'h0;
        end
        step(5);

        // Mode switched away from 11 mid-hold cancels later repeats.
        btn = 4'b1000;
        for (int j = 1; j <= 40; j++) begin
            step(1);
            rel = j - 6;
            if (rel == 16) check("switch_lp_pulse", pulse, 4'h8);
            if (rel == 24) check("switch_no_repeat24", pulse, 4'h0);
            if (rel == 32) check("switch_no_repeat32", pulse, 4'h0);
            if (rel == 20) mode = 8'h00;
        end
        btn = 4'h0;
        step(12);

        // Reset pulsed mid-press clears everything; button still held.
        mode = 8'b11_00_00_00;
        btn  = 4'b1000;
        step(26);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_level", level, 4'h0);
        check("midreset_pulse", pulse, 4'h0);
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k < 6) check("midreset_quiet", level | pulse | long_press, 4'h0);
            if (k == 6) check("midreset_repress_pulse", pulse, 4'h8);
        end
        btn = 4'h0;
        step(12);

        // Independent channels fire together.
        mode = 8'h00;
        btn  = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 5) check("indep_pulse_early", pulse, 4'h0);
            if (k == 6) check("indep_pulse", pulse, 4'hF);
        end
        btn = 4'h0;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
